// File: rtl/georgios_pkg.sv
// rtl/georgios_pkg.sv - shared widths, operand types and forwarding helper
package georgios_pkg;

    localparam int DATA_W = 8;
    localparam int SEL_W  = 4;
    localparam int DEPTH  = 2 ** SEL_W;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [SEL_W-1:0]  sel_t;

    // A read that lands on the address being written this cycle sees the new data.
    function automatic data_t fwd_data(
        input sel_t  rd_sel,
        input logic  wr_en,
        input sel_t  wr_sel,
        input data_t wr_data,
        input data_t stored
    );
        return (wr_en && (rd_sel == wr_sel)) ? wr_data : stored;
    endfunction

endpackage

// File: rtl/register_file_if.sv
// rtl/register_file_if.sv - router-to-register-file select/enable/data bundle
interface register_file_if;
    import georgios_pkg::*;

    sel_t  x_sel;
    sel_t  y_sel;
    sel_t  z_sel;
    logic  x_enb;
    logic  y_enb;
    logic  z_enb;
    data_t z;
    data_t x;
    data_t y;
    logic  x_valid;
    logic  y_valid;
    logic  z_ack;

    modport master (
        output x_sel, y_sel, z_sel, x_enb, y_enb, z_enb, z,
        input  x, y, x_valid, y_valid, z_ack
    );

    modport slave (
        input  x_sel, y_sel, z_sel, x_enb, y_enb, z_enb, z,
        output x, y, x_valid, y_valid, z_ack
    );

endinterface

// File: rtl/strobe_sync.sv
// rtl/strobe_sync.sv - two-flop synchronizer plus history flop, rising-edge strobe
module strobe_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic level_i,
    output logic strobe_o
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic hist_q,  hist_d;

    always_comb begin
        sync1_d = level_i;
        sync2_d = sync1_q;
        hist_d  = sync2_q;
    end

    // Resetting to 1 means a level already high at release looks "old", not new.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            hist_q  <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            hist_q  <= hist_d;
        end
    end

    assign strobe_o = sync2_q & ~hist_q;

endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - 16x8 register file, two read ports and one write port
import georgios_pkg::*;

module register_file (
    input  logic               clk,
    input  logic               rst_n,
    register_file_if.slave     bus
);

    logic x_stb;
    logic y_stb;
    logic z_stb;

    strobe_sync u_sync_x (.clk(clk), .rst_n(rst_n), .level_i(bus.x_enb), .strobe_o(x_stb));
    strobe_sync u_sync_y (.clk(clk), .rst_n(rst_n), .level_i(bus.y_enb), .strobe_o(y_stb));
    strobe_sync u_sync_z (.clk(clk), .rst_n(rst_n), .level_i(bus.z_enb), .strobe_o(z_stb));

    data_t mem_q [DEPTH];
    data_t mem_d [DEPTH];
    data_t x_q, x_d;
    data_t y_q, y_d;
    logic  x_valid_q, x_valid_d;
    logic  y_valid_q, y_valid_d;
    logic  z_ack_q,   z_ack_d;

    always_comb begin
        mem_d     = mem_q;
        x_d       = x_q;
        y_d       = y_q;
        x_valid_d = x_stb;
        y_valid_d = y_stb;
        z_ack_d   = z_stb;
        if (z_stb) begin
            mem_d[bus.z_sel] = bus.z;
        end
        if (x_stb) begin
            x_d = fwd_data(bus.x_sel, z_stb, bus.z_sel, bus.z, mem_q[bus.x_sel]);
        end
        if (y_stb) begin
            y_d = fwd_data(bus.y_sel, z_stb, bus.z_sel, bus.z, mem_q[bus.y_sel]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q     <= '{default: '0};
            x_q       <= '0;
            y_q       <= '0;
            x_valid_q <= 1'b0;
            y_valid_q <= 1'b0;
            z_ack_q   <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            x_q       <= x_d;
            y_q       <= y_d;
            x_valid_q <= x_valid_d;
            y_valid_q <= y_valid_d;
            z_ack_q   <= z_ack_d;
        end
    end

    assign bus.x       = x_q;
    assign bus.y       = y_q;
    assign bus.x_valid = x_valid_q;
    assign bus.y_valid = y_valid_q;
    assign bus.z_ack   = z_ack_q;

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - scoreboard bench for register_file
module tb_register_file;
    import georgios_pkg::*;

    typedef struct {
        data_t data;
        int    cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    register_file_if bus();

    register_file dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    ack_count = 0;
    exp_t  exp_x[$];
    exp_t  exp_y[$];
    exp_t  exp_z[$];
    data_t model [DEPTH];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_pulse(input string tag, input bit has_data, input data_t got,
                               input int n, input exp_t e);
        checks++;
        assert (n > 0) else begin
            errors++;
            $error("FAIL %s_unexpected: pulse at cycle %0d, required none", tag, cyc);
        end
        if (n > 0) begin
            if (has_data) begin
                checks++;
                assert (got === e.data) else begin
                    errors++;
                    $error("FAIL %s_data: got %h required %h", tag, got, e.data);
                end
            end
            checks++;
            assert (cyc === e.cyc) else begin
                errors++;
                $error("FAIL %s_latency: pulse at cycle %0d required %0d", tag, cyc, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   n;
        if (rst_n) begin
            if (bus.x_valid) begin
                e.data = '0; e.cyc = 0;
                n = exp_x.size();
                if (n > 0) e = exp_x.pop_front();
                check_pulse("x", 1'b1, bus.x, n, e);
            end
            if (bus.y_valid) begin
                e.data = '0; e.cyc = 0;
                n = exp_y.size();
                if (n > 0) e = exp_y.pop_front();
                check_pulse("y", 1'b1, bus.y, n, e);
            end
            if (bus.z_ack) begin
                ack_count++;
                e.data = '0; e.cyc = 0;
                n = exp_z.size();
                if (n > 0) e = exp_z.pop_front();
                check_pulse("z_ack", 1'b0, '0, n, e);
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] req);
        checks++;
        assert (got === req) else begin
            errors++;
            $error("FAIL %s: got %0h required %0h", tag, got, req);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    // Enables rise on a falling edge, so commit lands exactly three posedges later.
    task automatic req(input bit xe, input bit ye, input bit ze,
                       input sel_t xs, input sel_t ys, input sel_t zs,
                       input data_t zd, input int high);
        exp_t e;
        @(negedge clk);
        bus.x_sel = xs;
        bus.y_sel = ys;
        bus.z_sel = zs;
        bus.z     = zd;
        if (ze) begin
            model[zs] = zd;
            e.data = zd; e.cyc = cyc + 3;
            exp_z.push_back(e);
        end
        if (xe) begin
            e.data = model[xs]; e.cyc = cyc + 3;
            exp_x.push_back(e);
        end
        if (ye) begin
            e.data = model[ys]; e.cyc = cyc + 3;
            exp_y.push_back(e);
        end
        bus.x_enb = xe;
        bus.y_enb = ye;
        bus.z_enb = ze;
        repeat (high) @(negedge clk);
        bus.x_enb = 1'b0;
        bus.y_enb = 1'b0;
        bus.z_enb = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int   acks_before;
        exp_t e;
        bus.x_sel = '0; bus.y_sel = '0; bus.z_sel = '0; bus.z = '0;
        bus.x_enb = 1'b0; bus.y_enb = 1'b0; bus.z_enb = 1'b0;
        clear_model();

        repeat (3) @(negedge clk);
        check_val("reset_x", 32'(bus.x), 32'h0);
        check_val("reset_y", 32'(bus.y), 32'h0);
        check_val("reset_x_valid", 32'(bus.x_valid), 32'h0);
        check_val("reset_y_valid", 32'(bus.y_valid), 32'h0);
        check_val("reset_z_ack", 32'(bus.z_ack), 32'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < DEPTH; i++) begin
            req(1'b1, 1'b1, 1'b0, sel_t'(i), sel_t'(DEPTH - 1 - i), '0, '0, 3);
        end

        req(1'b0, 1'b0, 1'b1, '0, '0, sel_t'(3), 8'hA5, 3);
        req(1'b1, 1'b0, 1'b0, sel_t'(3), '0, '0, '0, 3);
        req(1'b0, 1'b1, 1'b0, '0, sel_t'(2), '0, '0, 3);
        check_val("x_held", 32'(bus.x), 32'hA5);
        req(1'b0, 1'b1, 1'b0, '0, sel_t'(4), '0, '0, 3);

        req(1'b1, 1'b1, 1'b1, sel_t'(7), sel_t'(7), sel_t'(7), 8'h3C, 3);

        acks_before = ack_count;
        req(1'b0, 1'b0, 1'b1, '0, '0, sel_t'(1), 8'h11, 3);
        req(1'b0, 1'b0, 1'b1, '0, '0, sel_t'(1), 8'h22, 3);
        req(1'b1, 1'b0, 1'b0, sel_t'(1), '0, '0, '0, 3);
        check_val("b2b_ack_count", 32'(ack_count - acks_before), 32'd2);

        @(negedge clk);
        bus.x_sel = sel_t'(7);
        e.data = model[7]; e.cyc = cyc + 3;
        exp_x.push_back(e);
        bus.x_enb = 1'b1;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        check_val("midrst_x", 32'(bus.x), 32'h0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        bus.x_enb = 1'b0;
        repeat (2) @(negedge clk);
        req(1'b1, 1'b1, 1'b0, sel_t'(7), sel_t'(3), '0, '0, 3);

        bus.z_sel = sel_t'(5);
        bus.z     = 8'hFF;
        bus.z_enb = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        bus.z_enb = 1'b0;
        repeat (3) @(negedge clk);
        req(1'b1, 1'b0, 1'b0, sel_t'(5), '0, '0, '0, 3);

        req(1'b0, 1'b0, 1'b1, '0, '0, sel_t'(0), 8'h5A, 3);
        req(1'b1, 1'b1, 1'b0, sel_t'(0), sel_t'(5), '0, '0, 3);

        repeat (6) @(negedge clk);
        check_val("x_drained", 32'(exp_x.size()), 32'd0);
        check_val("y_drained", 32'(exp_y.size()), 32'd0);
        check_val("z_drained", 32'(exp_z.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_file.md
# register_file

Clocked 16-entry × 8-bit register file answering the select/enable strobes driven by the operand router. It has two read ports (x, y) and one write port (z). Each enable input is treated as an asynchronous request level. The block synchronizes it and edge-detects it, then performs the read or write and reports completion. It sits between the router and the ALU datapath: reads feed the router's `x`/`y` inputs, and the router's `z` output is written back.

## Interface
- `w`, 8, data width
- `sel_w`, 4, register-select width; depth = 2**sel_w
- `clk`  in  1  system clock, rising-edge active
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low
- `x_sel`, `y_sel`  in  sel_w  read-port register selects
- `z_sel`  in  sel_w  write-port register select
- `x_enb`, `y_enb`, `z_enb`  in  1  port request levels, asynchronous to `clk`
- `z`  in  w  write data
- `x`, `y`  out  w  read data, held until the next read on that port
- `x_valid`, `y_valid`  out  1  one-cycle pulse: new read data present
- `z_ack`  out  1  one-cycle pulse: write committed

## Operation
- Each `*_enb` passes through a 2-flop synchronizer plus a history flop.
- A port strobe fires only on a synchronized 0→1 transition.
- Falling edges do nothing.
- Read strobe on port p:
  - Register `mem[p_sel]` into p.
  - Pulse `p_valid`.
- Write strobe:
  - `mem[z_sel] <= z`.
  - Pulse `z_ack`.
- Selects and `z` are sampled on the strobe cycle only.
- Write/read same cycle, same address: the read returns the new `z` (write-through forwarding). `mem` also updates.
- x and y reading the same address in the same cycle is legal; both get identical data.
- All three strobes in one cycle are legal and are serviced in parallel.
- No register is hardwired; entry 0 is ordinary storage.
- Reset (async assert):
  - `mem` all 0.
  - `x` = `y` = 0.
  - `x_valid`, `y_valid`, `z_ack` = 0.
  - All synchronizer and history flops = 1.
  - Consequence: an enable already high at reset release produces no strobe.
  - An enable low at reset release produces no strobe; it is only a 1→0 transition.
- Reset mid-operation: an in-flight strobe is discarded. No partial write or valid pulse appears after release.

## Timing
- `*_enb` rises before clock edge k and is captured by sync stage 1 at k.
- Sync stage 2 captures it at k+1; the strobe is combinationally high during cycle k+1..k+2.
- At edge k+2 the action commits:
  - Read: `x`/`y` update and `p_valid` goes high for the cycle after k+2.
  - Write: `mem` updates and `z_ack` goes high for the cycle after k+2.
- Latency: enable rise to valid/ack = 2–3 clocks, depending on phase.
- Requester obligations:
  - Selects and `z` stable from before enable rise through edge k+2, i.e. ≥3 clocks after the rise.
  - Enable high ≥3 clocks and low ≥2 clocks between requests.
  - Shorter pulses give undefined results, but must never corrupt an unselected entry.
- A read of an address written in an earlier strobe cycle returns the new data (no extra hazard cycle).
- Outputs are all registered; no combinational path from inputs to outputs.

## Structure
- Shared package `georgios_pkg`:
  - Constants `DATA_W` = 8 and `SEL_W` = 4.
  - Type `data_t` [DATA_W-1:0].
  - Type `sel_t` [SEL_W-1:0].
  - The router and ALU reuse these.
- Sub-module `strobe_sync`:
  - Ports: `clk`, `rst_n`, level in, one-cycle strobe out.
  - Contains the 2-flop synchronizer and history flop, all reset to 1.
  - Instantiated three times (x, y, z).
- Top level holds the `mem` array, the forwarding muxes, and the output/valid registers.

## Test plan
- Reset then read all 16 entries via x and y in turn → every read returns 0x00; one `x_valid`/`y_valid` pulse per request.
- Write 0xA5 to r3, then read r3 on x → `z_ack` pulse, then x = 0xA5 with `x_valid` 2–3 clocks after the `x_enb` rise; r2 and r4 still 0x00.
- Same-cycle `z_enb` (r7 ← 0x3C) and `x_enb`/`y_enb` both selecting r7 → x = y = 0x3C, both valids pulse on the same cycle as `z_ack`.
- Hold `x_enb` high for 10 clocks → exactly one `x_valid` pulse. Then assert `rst_n` with `x_enb` still high and release → no `x_valid` until `x_enb` drops and rises again.
- Assert `rst_n` one clock after a `z_enb` rise (r5 ← 0xFF) → no `z_ack`, r5 reads 0x00 after reset.
- Back-to-back writes r1 ← 0x11, r1 ← 0x22 with minimum legal spacing, then read r1 → 0x22; exactly two `z_ack` pulses.
